tx_burst_scheduler: RTL and testbench

TX_BURST_SCHEDULER -- requirements
Module: tx_burst_scheduler

---
 rtl/sonar_pkg.sv | 32 +++
 rtl/tx_channel_gen.sv | 106 ++++++++++
 rtl/tx_burst_scheduler.sv | 116 +++++++++++
 tb/tb_tx_burst_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared types and defaults for the sonar transmit burst scheduler
package sonar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRE,
        ST_DONE
    } burst_state_e;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_WAIT,
        CH_RUN,
        CH_FIN
    } ch_phase_e;

    localparam int DEF_HALF_PERIOD_CYCLES = 1250;
    localparam int DEF_NUM_CARRIER_CYCLES = 8;
    localparam int DEF_NUM_CH             = 4;
    localparam int DEF_DLY_W              = 8 + $clog2(DEF_NUM_CH);

    // Worst-case steering delay is 255*(num_ch-1), which always fits in 8+clog2(num_ch) bits.
    function automatic int dly_width(input int num_ch);
        return 8 + $clog2(num_ch);
    endfunction

    // Bits for a counter running 0..n_states-1, never narrower than one bit.
    function automatic int cnt_width(input int n_states);
        return (n_states > 1) ? $clog2(n_states) : 1;
    endfunction

endpackage

// File: rtl/tx_channel_gen.sv
// rtl/tx_channel_gen.sv - one transmitter channel: steering delay, then a fixed train of carrier periods
module tx_channel_gen
    import sonar_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = DEF_HALF_PERIOD_CYCLES,
    parameter int NUM_CARRIER_CYCLES = DEF_NUM_CARRIER_CYCLES,
    parameter int DLY_W              = DEF_DLY_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [DLY_W-1:0] delay_in,
    input  logic             abort_in,
    output logic             tx_out,
    output logic             finished_out
);

    localparam int HW = cnt_width(HALF_PERIOD_CYCLES);
    localparam int NW = cnt_width(NUM_CARRIER_CYCLES);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD_CYCLES - 1);
    localparam logic [NW-1:0] PER_LAST  = NW'(NUM_CARRIER_CYCLES - 1);

    ch_phase_e        phase_q, phase_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [HW-1:0]    half_q, half_d;
    logic [NW-1:0]    per_q, per_d;
    logic             tx_q, tx_d;
    logic             last_cycle;

    // High during the final low half-period so the scheduler can leave FIRE on the same edge.
    assign last_cycle = (phase_q == CH_RUN) && !tx_q && (half_q == HALF_LAST) && (per_q == PER_LAST);

    always_comb begin
        phase_d = phase_q;
        dly_d   = dly_q;
        half_d  = half_q;
        per_d   = per_q;
        tx_d    = tx_q;
        if (abort_in) begin
            phase_d = CH_IDLE;
            dly_d   = '0;
            half_d  = '0;
            per_d   = '0;
            tx_d    = 1'b0;
        end else if (start_in) begin
            half_d = '0;
            per_d  = '0;
            if (delay_in == '0) begin
                phase_d = CH_RUN;
                dly_d   = '0;
                tx_d    = 1'b1;
            end else begin
                phase_d = CH_WAIT;
                dly_d   = delay_in;
                tx_d    = 1'b0;
            end
        end else begin
            unique case (phase_q)
                CH_WAIT: begin
                    if (dly_q == DLY_W'(1)) begin
                        phase_d = CH_RUN;
                        tx_d    = 1'b1;
                    end else begin
                        dly_d = dly_q - DLY_W'(1);
                    end
                end
                CH_RUN: begin
                    if (half_q == HALF_LAST) begin
                        half_d = '0;
                        if (tx_q) begin
                            tx_d = 1'b0;
                        end else if (per_q == PER_LAST) begin
                            phase_d = CH_FIN;
                        end else begin
                            per_d = per_q + NW'(1);
                            tx_d  = 1'b1;
                        end
                    end else begin
                        half_d = half_q + HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            phase_q <= CH_IDLE;
            dly_q   <= '0;
            half_q  <= '0;
            per_q   <= '0;
            tx_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dly_q   <= dly_d;
            half_q  <= half_d;
            per_q   <= per_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_out       = tx_q;
    assign finished_out = (phase_q == CH_FIN) || last_cycle;

endmodule

// File: rtl/tx_burst_scheduler.sv
// rtl/tx_burst_scheduler.sv - steered multi-channel ultrasonic burst scheduler
// Define TX_BURST_COUNT_EN to build the 16-bit completed-burst counter; otherwise burst_count_out is tied to 0.
module tx_burst_scheduler
    import sonar_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = DEF_HALF_PERIOD_CYCLES,
    parameter int NUM_CARRIER_CYCLES = DEF_NUM_CARRIER_CYCLES,
    parameter int NUM_CH             = DEF_NUM_CH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              trigger_in,
    input  logic [7:0]        step_in,
    input  logic              dir_in,
    input  logic              abort_in,
    output logic [NUM_CH-1:0] tx_out,
    output logic              burst_start_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [15:0]       burst_count_out
);

    localparam int DLY_W = dly_width(NUM_CH);

    burst_state_e state_q, state_d;
    logic         start_q, start_d;
    logic         accept;
    logic         ch_abort;
    logic [NUM_CH-1:0]            ch_fin;
    logic [NUM_CH-1:0][DLY_W-1:0] ch_dly;

    assign accept   = (state_q == ST_IDLE) && trigger_in && !abort_in;
    assign ch_abort = (state_q == ST_FIRE) && abort_in;

    // Each channel captures its delay on the accepting edge, so later step/dir changes are ignored.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [DLY_W-1:0] FWD = DLY_W'(i);
        localparam logic [DLY_W-1:0] REV = DLY_W'(NUM_CH - 1 - i);

        assign ch_dly[i] = DLY_W'(step_in) * (dir_in ? REV : FWD);

        tx_channel_gen #(
            .HALF_PERIOD_CYCLES(HALF_PERIOD_CYCLES),
            .NUM_CARRIER_CYCLES(NUM_CARRIER_CYCLES),
            .DLY_W             (DLY_W)
        ) u_ch (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .start_in    (accept),
            .delay_in    (ch_dly[i]),
            .abort_in    (ch_abort),
            .tx_out      (tx_out[i]),
            .finished_out(ch_fin[i])
        );
    end

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_FIRE;
                    start_d = 1'b1;
                end
            end
            ST_FIRE: begin
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else if (&ch_fin) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    assign burst_start_out = start_q;
    assign busy_out        = (state_q == ST_FIRE);
    assign done_out        = (state_q == ST_DONE);

`ifdef TX_BURST_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == ST_DONE) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign burst_count_out = count_q;
`else
    assign burst_count_out = '0;
`endif

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// tb/tb_tx_burst_scheduler.sv - scoreboard bench for tx_burst_scheduler with a timing-rule reference model
module tb_tx_burst_scheduler;

    localparam int H   = 4;
    localparam int N   = 2;
    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           trig = 1'b0;
    logic [7:0]     step = '0;
    logic           dir = 1'b0;
    logic           abort = 1'b0;
    logic [NCH-1:0] tx;
    logic           bstart;
    logic           busy;
    logic           done;
    logic [15:0]    cnt;

    always #5 clk = ~clk;

    tx_burst_scheduler #(
        .HALF_PERIOD_CYCLES(H),
        .NUM_CARRIER_CYCLES(N),
        .NUM_CH            (NCH)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .trigger_in     (trig),
        .step_in        (step),
        .dir_in         (dir),
        .abort_in       (abort),
        .tx_out         (tx),
        .burst_start_out(bstart),
        .busy_out       (busy),
        .done_out       (done),
        .burst_count_out(cnt)
    );

    typedef struct {
        logic [NCH-1:0] tx;
        logic           start;
        logic           busy;
        logic           done;
        logic [15:0]    cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_fail = 0;
    int done_seen = 0;

    // Reference model: a burst is an acceptance edge plus per-channel delays; outputs follow from elapsed time.
    bit m_active = 1'b0;
    int m_t = 0;
    int m_l = 0;
    int m_d[NCH];
    int m_count = 0;
    int m_completed = 0;
    int edge_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   k;
        int   off;
        e.tx    = '0;
        e.start = 1'b0;
        e.busy  = 1'b0;
        e.done  = 1'b0;
        e.cnt   = 16'(m_count);
        if (m_active) begin
            k       = edge_no + 1 - m_t;
            e.start = (k == 1);
            e.busy  = (k >= 1) && (k <= m_l);
            e.done  = (k == m_l + 1);
            for (int i = 0; i < NCH; i++) begin
                off      = k - 1 - m_d[i];
                e.tx[i]  = (off >= 0) && (off < 2 * H * N) && (((off / H) % 2) == 0);
            end
        end
        return e;
    endfunction

    task automatic model_edge(input bit t, input int s, input bit d, input bit a);
        int dmax;
        edge_no++;
        if (m_active) begin
            if (a && edge_no <= m_t + m_l) begin
                m_active = 1'b0;
            end else if (edge_no == m_t + m_l + 1) begin
                m_active = 1'b0;
                m_completed++;
`ifdef TX_BURST_COUNT_EN
                m_count = (m_count + 1) % 65536;
`endif
            end
        end else if (t && !a) begin
            m_active = 1'b1;
            m_t      = edge_no;
            dmax     = 0;
            for (int i = 0; i < NCH; i++) begin
                m_d[i] = s * (d ? (NCH - 1 - i) : i);
                if (m_d[i] > dmax) dmax = m_d[i];
            end
            m_l = dmax + 2 * H * N;
        end
    endtask

    task automatic drive_cycle(input bit t, input int s, input bit d, input bit a);
        trig  = t;
        step  = 8'(s);
        dir   = d;
        abort = a;
        @(posedge clk);
        #1;
        model_edge(t, s, d, a);
        sb_q.push_back(model_out());
    endtask

    function automatic int rand_step();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b0, rand_step(), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " tx_out"}, 32'(tx), 32'd0);
        check({tag, " burst_start_out"}, 32'(bstart), 32'd0);
        check({tag, " busy_out"}, 32'(busy), 32'd0);
        check({tag, " done_out"}, 32'(done), 32'd0);
        check({tag, " burst_count_out"}, 32'(cnt), 32'd0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst   = 1'b1;
        trig  = 1'b0;
        abort = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        m_active = 1'b0;
        m_count  = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && done) done_seen++;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("tx_out", 32'(tx), 32'(mon_e.tx));
            check("burst_start_out", 32'(bstart), 32'(mon_e.start));
            check("busy_out", 32'(busy), 32'(mon_e.busy));
            check("done_out", 32'(done), 32'(mon_e.done));
            check("burst_count_out", 32'(cnt), 32'(mon_e.cnt));
        end
    end

    initial begin
        #3;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // In-phase burst straight out of reset
        drive_cycle(1'b1, 0, 1'b0, 1'b0);
        idle(20);

        // Forward steering
        drive_cycle(1'b1, 3, 1'b0, 1'b0);
        idle(30);

        // Reverse steering while step/dir wander mid-burst
        drive_cycle(1'b1, 3, 1'b1, 1'b0);
        idle(30);

        // Retrigger at T+5 is ignored
        drive_cycle(1'b1, 2, 1'b0, 1'b0);
        idle(4);
        drive_cycle(1'b1, 5, 1'b1, 1'b0);
        idle(40);

        // Abort at T+6
        drive_cycle(1'b1, 1, 1'b0, 1'b0);
        idle(5);
        drive_cycle(1'b0, 1, 1'b0, 1'b1);
        idle(10);

        // Abort beats trigger in IDLE
        drive_cycle(1'b1, 2, 1'b0, 1'b1);
        idle(5);

        // Trigger during DONE is dropped, the next edge is accepted
        drive_cycle(1'b1, 0, 1'b0, 1'b0);
        idle(16);
        drive_cycle(1'b1, 0, 1'b0, 1'b0);
        drive_cycle(1'b1, 0, 1'b0, 1'b0);
        idle(20);

        // Widest steering
        drive_cycle(1'b1, 255, 1'b1, 1'b0);
        idle(790);

        // Abort on the final FIRE cycle suppresses done
        drive_cycle(1'b1, 0, 1'b0, 1'b0);
        idle(15);
        drive_cycle(1'b0, 0, 1'b0, 1'b1);
        idle(5);

        for (int i = 0; i < 2500; i++) begin
            drive_cycle($urandom_range(0, 11) == 0, rand_step(), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 79) == 0);
        end
        idle(800);

        // Reset mid-burst, then a normal trigger
        drive_cycle(1'b1, 4, 1'b0, 1'b0);
        idle(7);
        mid_reset();
        drive_cycle(1'b1, 1, 1'b1, 1'b0);
        idle(30);

        for (int i = 0; i < 1000; i++) begin
            drive_cycle($urandom_range(0, 9) == 0, rand_step(), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 59) == 0);
        end
        idle(800);

        @(negedge clk);
        #1;
        check("completed_bursts", 32'(done_seen), 32'(m_completed));
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
